reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/rob_pkg.sv | 22 ++
 rtl/rob_storage.sv | 96 +++++++++
 rtl/reorder_buffer.sv | 167 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared sizing constants and the reorder-buffer entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rob_pkg;

    localparam int ROB_DEPTH = 32;
    localparam int TAG_W     = $clog2(ROB_DEPTH);
    localparam int CNT_W     = TAG_W + 1;
    localparam int REG_W     = 5;
    localparam int XLEN      = 32;

    // One in-flight instruction: allocation state, result and branch outcome.
    typedef struct packed {
        logic             busy;
        logic             ready;
        logic             mispredict;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  val;
        logic [XLEN-1:0]  target;
    } rob_entry_t;

endpackage

// File: rtl/rob_storage.sv
// Entry array: one allocate port, one writeback port, head read and two operand queries.
// Latency: writes land at the next rising edge; queries are combinational with writeback bypass.
// Backpressure: none; the controller only allocates free slots and retires ready ones.
module rob_storage
    import rob_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_all,
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  logic [REG_W-1:0] alloc_rd,
    input  logic             wb_vld,
    input  logic             wb_en,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [XLEN-1:0]  wb_val,
    input  logic             wb_mispredict,
    input  logic [XLEN-1:0]  wb_target,
    input  logic             retire_en,
    input  logic [TAG_W-1:0] head_tag,
    output logic             head_ready,
    output logic             head_mispredict,
    output logic [REG_W-1:0] head_rd,
    output logic [XLEN-1:0]  head_val,
    output logic [XLEN-1:0]  head_target,
    input  logic [TAG_W-1:0] q1_tag,
    output logic             q1_ready,
    output logic [XLEN-1:0]  q1_val,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q2_ready,
    output logic [XLEN-1:0]  q2_val
);

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];

    // Next array contents: allocate, then result capture, then retire; a flush wipes everything.
    always_comb begin
        entries_d = entries_q;
        if (alloc_en) begin
            entries_d[alloc_tag]            = '0;
            entries_d[alloc_tag].busy       = 1'b1;
            entries_d[alloc_tag].rd         = alloc_rd;
        end
        // Results for slots that are not in flight are stale and dropped.
        if (wb_en && entries_q[wb_tag].busy) begin
            entries_d[wb_tag].ready      = 1'b1;
            entries_d[wb_tag].val        = wb_val;
            entries_d[wb_tag].mispredict = wb_mispredict;
            entries_d[wb_tag].target     = wb_target;
        end
        if (retire_en) begin
            entries_d[head_tag] = '0;
        end
        if (clear_all) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end
    end

    // Array state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            entries_q <= entries_d;
        end
    end

    // Head read for the retire decision and operand queries with same-cycle result bypass.
    always_comb begin
        head_ready      = entries_q[head_tag].ready;
        head_mispredict = entries_q[head_tag].mispredict;
        head_rd         = entries_q[head_tag].rd;
        head_val        = entries_q[head_tag].val;
        head_target     = entries_q[head_tag].target;
        q1_ready        = entries_q[q1_tag].ready;
        q1_val          = entries_q[q1_tag].val;
        q2_ready        = entries_q[q2_tag].ready;
        q2_val          = entries_q[q2_tag].val;
        if (wb_vld && (wb_tag == q1_tag)) begin
            q1_ready = 1'b1;
            q1_val   = wb_val;
        end
        if (wb_vld && (wb_tag == q2_tag)) begin
            q2_ready = 1'b1;
            q2_val   = wb_val;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates tags at issue, collects results, retires from head.
// Latency: result sampled at edge N retires (commit_en) after edge N+1; flush registered with the retire.
// Backpressure: issue_ready drops when all entries are allocated; it reopens the cycle after a retire.
module reorder_buffer #(
    parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [rob_pkg::REG_W-1:0] issue_rd,
    output logic                      issue_ready,
    output logic [rob_pkg::TAG_W-1:0] issue_tag,
    output logic                      dep_set_en,
    output logic [rob_pkg::REG_W-1:0] dep_reg,
    output logic [rob_pkg::TAG_W-1:0] dep_tag,
    input  logic                      wb_valid,
    input  logic [rob_pkg::TAG_W-1:0] wb_tag,
    input  logic [rob_pkg::XLEN-1:0]  wb_val,
    input  logic                      wb_mispredict,
    input  logic [rob_pkg::XLEN-1:0]  wb_target,
    input  logic [rob_pkg::TAG_W-1:0] q1_tag,
    input  logic [rob_pkg::TAG_W-1:0] q2_tag,
    output logic                      q1_ready,
    output logic [rob_pkg::XLEN-1:0]  q1_val,
    output logic                      q2_ready,
    output logic [rob_pkg::XLEN-1:0]  q2_val,
    output logic                      commit_en,
    output logic [rob_pkg::TAG_W-1:0] commit_tag,
    output logic [rob_pkg::REG_W-1:0] commit_rd,
    output logic [rob_pkg::XLEN-1:0]  commit_val,
    output logic                      flush,
    output logic [rob_pkg::XLEN-1:0]  flush_pc
);
    import rob_pkg::*;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROB_DEPTH);
    localparam logic [TAG_W-1:0] LAST_PTR = TAG_W'(ROB_DEPTH - 1);

    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             commit_en_q, commit_en_d;
    logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
    logic [REG_W-1:0] commit_rd_q, commit_rd_d;
    logic [XLEN-1:0]  commit_val_q, commit_val_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

    logic             head_ready, head_mispredict;
    logic [REG_W-1:0] head_rd;
    logic [XLEN-1:0]  head_val, head_target;
    logic             commit_go, flush_go, issue_acc;

    // Edge decisions: retire when the head has its result; a mispredicted retire also flushes.
    always_comb begin
        issue_ready = (count_q < FULL_CNT);
        issue_tag   = tail_q;
        commit_go   = (count_q != '0) && head_ready;
        flush_go    = commit_go && head_mispredict;
        issue_acc   = issue_valid && issue_ready && !flush_go;
        dep_set_en  = issue_valid && issue_ready && (issue_rd != '0);
        dep_reg     = issue_rd;
        dep_tag     = tail_q;
    end

    // Pointer, occupancy and retire/flush output next-state.
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        commit_en_d  = commit_go;
        commit_tag_d = commit_tag_q;
        commit_rd_d  = commit_rd_q;
        commit_val_d = commit_val_q;
        flush_d      = flush_go;
        flush_pc_d   = flush_pc_q;
        if (commit_go) begin
            commit_tag_d = head_q;
            commit_rd_d  = head_rd;
            commit_val_d = head_val;
        end
        if (flush_go) begin
            flush_pc_d = head_target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue_acc) begin
                tail_d = ptr_inc(tail_q);
            end
            if (commit_go) begin
                head_d = ptr_inc(head_q);
            end
            case ({issue_acc, commit_go})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            commit_en_q  <= 1'b0;
            commit_tag_q <= '0;
            commit_rd_q  <= '0;
            commit_val_q <= '0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_en_q  <= commit_en_d;
            commit_tag_q <= commit_tag_d;
            commit_rd_q  <= commit_rd_d;
            commit_val_q <= commit_val_d;
            flush_q      <= flush_d;
            flush_pc_q   <= flush_pc_d;
        end
    end

    assign commit_en  = commit_en_q;
    assign commit_tag = commit_tag_q;
    assign commit_rd  = commit_rd_q;
    assign commit_val = commit_val_q;
    assign flush      = flush_q;
    assign flush_pc   = flush_pc_q;

    rob_storage #(
        .DEPTH(ROB_DEPTH)
    ) u_storage (
        .clk            (clk),
        .rst            (rst),
        .clear_all      (flush_go),
        .alloc_en       (issue_acc),
        .alloc_tag      (tail_q),
        .alloc_rd       (issue_rd),
        .wb_vld         (wb_valid),
        .wb_en          (wb_valid && !flush_go),
        .wb_tag         (wb_tag),
        .wb_val         (wb_val),
        .wb_mispredict  (wb_mispredict),
        .wb_target      (wb_target),
        .retire_en      (commit_go),
        .head_tag       (head_q),
        .head_ready     (head_ready),
        .head_mispredict(head_mispredict),
        .head_rd        (head_rd),
        .head_val       (head_val),
        .head_target    (head_target),
        .q1_tag         (q1_tag),
        .q1_ready       (q1_ready),
        .q1_val         (q1_val),
        .q2_tag         (q2_tag),
        .q2_ready       (q2_ready),
        .q2_val         (q2_val)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, ordering, full, flush, bypass and reset.
// Latency: inputs change 1 time unit after each rising edge, outputs are sampled there too.
// Backpressure: issue_valid is held while issue_ready is low to probe the full case.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  issue_tag;
    logic        dep_set_en;
    logic [4:0]  dep_reg;
    logic [4:0]  dep_tag;
    logic        wb_valid;
    logic [4:0]  wb_tag;
    logic [31:0] wb_val;
    logic        wb_mispredict;
    logic [31:0] wb_target;
    logic [4:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        commit_en;
    logic [4:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic        flush;
    logic [31:0] flush_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .issue_tag    (issue_tag),
        .dep_set_en   (dep_set_en),
        .dep_reg      (dep_reg),
        .dep_tag      (dep_tag),
        .wb_valid     (wb_valid),
        .wb_tag       (wb_tag),
        .wb_val       (wb_val),
        .wb_mispredict(wb_mispredict),
        .wb_target    (wb_target),
        .q1_tag       (q1_tag),
        .q2_tag       (q2_tag),
        .q1_ready     (q1_ready),
        .q1_val       (q1_val),
        .q2_ready     (q2_ready),
        .q2_val       (q2_val),
        .commit_en    (commit_en),
        .commit_tag   (commit_tag),
        .commit_rd    (commit_rd),
        .commit_val   (commit_val),
        .flush        (flush),
        .flush_pc     (flush_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; issue_valid = 1'b0; issue_rd = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_val = '0; wb_mispredict = 1'b0; wb_target = '0;
        q1_tag = '0; q2_tag = '0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_commit_en", commit_en, 0);
        chk("rst_commit_tag", commit_tag, 0);
        chk("rst_commit_val", commit_val, 0);
        chk("rst_flush", flush, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_issue_tag", issue_tag, 0);
        chk("rst_count", dut.count_q, 0);

        // Single issue, writeback, commit
        issue_valid = 1'b1; issue_rd = 5'd5; #1;
        chk("t1_dep_set_en", dep_set_en, 1);
        chk("t1_dep_reg", dep_reg, 5);
        chk("t1_dep_tag", dep_tag, 0);
        step();
        issue_valid = 1'b0;
        chk("t1_count_after_issue", dut.count_q, 1);
        wb_valid = 1'b1; wb_tag = 5'd0; wb_val = 32'h1234;
        step();
        wb_valid = 1'b0;
        chk("t1_no_early_commit", commit_en, 0);
        step();
        chk("t1_commit_en", commit_en, 1);
        chk("t1_commit_tag", commit_tag, 0);
        chk("t1_commit_rd", commit_rd, 5);
        chk("t1_commit_val", commit_val, 32'h1234);
        chk("t1_count_zero", dut.count_q, 0);
        step();
        chk("t1_commit_en_drop", commit_en, 0);

        // Out-of-order writeback, in-order commit
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd0; #1;
        chk("t2_dep_rd0", dep_set_en, 0);
        step();
        issue_rd = 5'd2; step();
        issue_rd = 5'd3; step();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 5'd2; wb_val = 32'h22; step();
        chk("t2_wait_a", commit_en, 0);
        wb_tag = 5'd1; wb_val = 32'h11; step();
        chk("t2_wait_b", commit_en, 0);
        wb_tag = 5'd0; wb_val = 32'h10; step();
        wb_valid = 1'b0;
        chk("t2_wait_c", commit_en, 0);
        step();
        chk("t2_c0_en", commit_en, 1);
        chk("t2_c0_tag", commit_tag, 0);
        chk("t2_c0_val", commit_val, 32'h10);
        step();
        chk("t2_c1_en", commit_en, 1);
        chk("t2_c1_tag", commit_tag, 1);
        chk("t2_c1_rd", commit_rd, 2);
        step();
        chk("t2_c2_en", commit_en, 1);
        chk("t2_c2_tag", commit_tag, 2);
        chk("t2_c2_val", commit_val, 32'h22);
        step();
        chk("t2_done_en", commit_en, 0);
        chk("t2_done_count", dut.count_q, 0);

        // Fill to capacity, overflow attempt, one commit reopens
        do_reset();
        issue_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            issue_rd = 5'(i % 31 + 1);
            step();
        end
        chk("t3_full_ready", issue_ready, 0);
        chk("t3_full_count", dut.count_q, 32);
        chk("t3_full_dep", dep_set_en, 0);
        chk("t3_tail_wrap", issue_tag, 0);
        step();
        chk("t3_overflow_count", dut.count_q, 32);
        wb_valid = 1'b1; wb_tag = 5'd0; wb_val = 32'h55;
        step();
        wb_valid = 1'b0;
        chk("t3_commit_cycle_ready", issue_ready, 0);
        step();
        chk("t3_commit_en", commit_en, 1);
        chk("t3_commit_tag", commit_tag, 0);
        chk("t3_commit_rd", commit_rd, 1);
        chk("t3_count_31", dut.count_q, 31);
        chk("t3_ready_next", issue_ready, 1);
        chk("t3_issue_tag0", issue_tag, 0);
        step();
        issue_valid = 1'b0;
        chk("t3_refill_count", dut.count_q, 32);
        chk("t3_refill_tag", issue_tag, 1);

        // Mispredict at tag 1 with younger entries in flight
        do_reset();
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_rd = 5'(i + 1);
            step();
        end
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 5'd0; wb_val = 32'h100; step();
        wb_tag = 5'd1; wb_val = 32'h200; wb_mispredict = 1'b1; wb_target = 32'h80; step();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
        chk("t4_c0_tag", commit_tag, 0);
        chk("t4_no_flush_yet", flush, 0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;
        chk("t4_commit_en", commit_en, 1);
        chk("t4_commit_tag", commit_tag, 1);
        chk("t4_flush", flush, 1);
        chk("t4_flush_pc", flush_pc, 32'h80);
        chk("t4_count", dut.count_q, 0);
        chk("t4_issue_tag", issue_tag, 0);
        wb_valid = 1'b1; wb_tag = 5'd2; wb_val = 32'h333;
        step();
        wb_valid = 1'b0;
        chk("t4_flush_one_cycle", flush, 0);
        chk("t4_flush_pc_hold", flush_pc, 32'h80);
        chk("t4_no_commit", commit_en, 0);
        q1_tag = 5'd2; #1;
        chk("t4_tag2_ignored", q1_ready, 0);
        step();
        chk("t4_still_no_commit", commit_en, 0);
        chk("t4_count_stays", dut.count_q, 0);

        // Operand query bypass and stored value
        q1_tag = 5'd3; q2_tag = 5'd4;
        wb_valid = 1'b1; wb_tag = 5'd3; wb_val = 32'hAB; #1;
        chk("t5_q1_ready", q1_ready, 1);
        chk("t5_q1_val", q1_val, 32'hAB);
        chk("t5_q2_not_ready", q2_ready, 0);
        wb_valid = 1'b0; #1;
        chk("t5_q1_no_bypass", q1_ready, 0);
        issue_valid = 1'b1; issue_rd = 5'd9; step();
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 5'd0; wb_val = 32'hCD; step();
        wb_valid = 1'b0; q2_tag = 5'd0; #1;
        chk("t5_q2_stored_ready", q2_ready, 1);
        chk("t5_q2_stored_val", q2_val, 32'hCD);
        step();
        chk("t5_commit_rd", commit_rd, 9);

        // Reset with ten entries in flight
        issue_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue_rd = 5'(i + 1);
            step();
        end
        chk("t6_count10", dut.count_q, 10);
        rst = 1'b1; wb_valid = 1'b1; wb_tag = 5'd1; wb_val = 32'h1;
        step();
        chk("t6_rst_commit_en", commit_en, 0);
        chk("t6_rst_count", dut.count_q, 0);
        chk("t6_rst_issue_tag", issue_tag, 0);
        rst = 1'b0; issue_valid = 1'b0; wb_valid = 1'b0;
        step();
        chk("t6_after_commit_en", commit_en, 0);
        chk("t6_after_count", dut.count_q, 0);
        chk("t6_after_ready", issue_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
